// File: rtl/mem_read_arbiter_if.sv
// Requester, memory and status signals of the shared cache-line read path.
interface mem_read_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 42,
    parameter int unsigned DATA_W  = 512
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      mem_rd_valid;
    logic [ADDR_W-1:0]         mem_rd_addr;
    logic                      mem_rd_ready;
    logic                      mem_data_valid;
    logic [DATA_W-1:0]         mem_data;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      busy;
    logic                      err_timeout;
    logic                      err_clear;

    // Requesters, memory block and error control.
    modport master (
        output req_valid, req_addr, mem_rd_ready, mem_data_valid, mem_data, err_clear,
        input  req_ready, mem_rd_valid, mem_rd_addr, rsp_valid, rsp_data, busy, err_timeout
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_addr, mem_rd_ready, mem_data_valid, mem_data, err_clear,
        output req_ready, mem_rd_valid, mem_rd_addr, rsp_valid, rsp_data, busy, err_timeout
    );
endinterface

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one cache-line read path among NUM_REQ requesters,
// one read outstanding, with a sticky timeout flag for lost reads.
module mem_read_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_W         = 42,
    parameter int unsigned DATA_W         = 512,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_read_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(NUM_REQ - 1);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RSP
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               mem_rd_valid_q, mem_rd_valid_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic               found_c;
    logic [PTR_W-1:0]   win_c;
    logic [PTR_W-1:0]   next_ptr_c;
    logic               timeout_c;
    int unsigned        idx;
    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign addr_arr[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
    end

    // First valid requester at or above rr_ptr, wrapping.
    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        idx     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % NUM_REQ;
            if (!found_c && bus.req_valid[PTR_W'(idx)]) begin
                found_c = 1'b1;
                win_c   = PTR_W'(idx);
            end
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE && found_c) ? (NUM_REQ'(1) << win_c) : '0;
    assign next_ptr_c    = (owner_q == PTR_LAST) ? '0 : owner_q + PTR_W'(1);
    assign timeout_c     = TIMEOUT_EN && (timer_q == TMR_LAST);

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        owner_d        = owner_q;
        addr_d         = addr_q;
        timer_d        = timer_q;
        mem_rd_valid_d = mem_rd_valid_q;
        rsp_valid_d    = '0;
        rsp_data_d     = rsp_data_q;
        err_d          = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (found_c) begin
                    addr_d         = addr_arr[win_c];
                    owner_d        = win_c;
                    mem_rd_valid_d = 1'b1;
                    state_d        = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_rd_valid_q && bus.mem_rd_ready) begin
                    mem_rd_valid_d = 1'b0;
                    timer_d        = '0;
                    state_d        = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                timer_d = timer_q + TMR_W'(1);
                // Data arriving in the timeout cycle still wins.
                if (bus.mem_data_valid) begin
                    rsp_data_d  = bus.mem_data;
                    rsp_valid_d = NUM_REQ'(1) << owner_q;
                    rr_ptr_d    = next_ptr_c;
                    state_d     = ST_IDLE;
                end else if (timeout_c) begin
                    err_d    = 1'b1;
                    rr_ptr_d = next_ptr_c;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.err_clear) err_d = 1'b0;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            owner_q        <= '0;
            addr_q         <= '0;
            timer_q        <= '0;
            mem_rd_valid_q <= 1'b0;
            rsp_valid_q    <= '0;
            rsp_data_q     <= '0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            owner_q        <= owner_d;
            addr_q         <= addr_d;
            timer_q        <= timer_d;
            mem_rd_valid_q <= mem_rd_valid_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
        end
    end

    assign bus.mem_rd_valid = mem_rd_valid_q;
    assign bus.mem_rd_addr  = addr_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.busy         = busy_q;
    assign bus.err_timeout  = err_q;

endmodule
